ethernet_rx_stream: RTL and testbench
=====================================

Name: ethernet_rx_stream

Overview:
Parametrised MII receive front end. It turns the 4-bit MII nibble stream into a byte-lane word stream with frame delimiting, FCS checking, optional FCS stripping and length policing.
- Runs entirely in the system clock domain; `ethernet_rx_clk` is oversampled, not used as a clock.
- Feeds the frame buffer / MAC filter stage and reports per-frame good/bad status.

Parameters:
- OUT_BYTES, 1, output word width in bytes; legal values 1, 2, 4.
- CHECK_FCS, 1, 1 = verify CRC-32 residue at frame end.
- STRIP_FCS, 0, 1 = the 4 FCS bytes are never emitted.
- MIN_LEN, 64, minimum frame length in bytes, destination address through FCS inclusive.
- MAX_LEN, 1518, maximum frame length in bytes, same counting.

Ports:
- clk  in  1  system clock; at least 4x the MII rx clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  receive enable.
- ethernet_rx_clk  in  1  MII receive clock, sampled.
- ethernet_rx_dv  in  1  MII data valid.
- ethernet_rx  in  4  MII receive nibble.
- ethernet_rx_er  in  1  MII receive error.
- ethernet_crs  in  1  carrier sense; unused except in the status output.
- out_valid  out  1  output word valid, one clk pulse per word.
- out_data  out  8*OUT_BYTES  data; byte 0 of the word in bits [7:0].
- out_keep  out  OUT_BYTES  byte-valid mask; all ones except on a last word.
- out_last  out  1  last word of frame.
- out_error  out  1  qualifies out_last; 1 = frame bad.
- frame_ok  out  1  one-cycle pulse, co-timed with a good out_last.
- frame_bad  out  1  one-cycle pulse, co-timed with a bad out_last.
- busy  out  1  FSM not IDLE, OR ethernet_crs.

Behaviour:
- Reset:
  - All outputs 0, FSM to IDLE.
  - CRC register set to 0xFFFFFFFF; counters and the FCS delay line cleared.
- Input sampling:
  - `ethernet_rx_clk`, `ethernet_rx_dv`, `ethernet_rx` and `ethernet_rx_er` pass through a 2-flop synchroniser.
  - A rising edge of the synchronised rx clock produces a one-clk `nib_stb`.
  - All MII logic advances only on `nib_stb`.
- FSM states (2-bit): IDLE=00, PREAMBLE=01, DATA=10, DROP=11.
- IDLE:
  - dv=1 and start=1 goes to PREAMBLE.
  - dv=1 and start=0 goes to DROP.
- PREAMBLE:
  - Nibble 0x5 stays in PREAMBLE.
  - Nibble 0xD (SFD) goes to DATA and clears the CRC register, byte count and error flag.
  - Any other nibble goes to DROP.
  - dv=0 goes to IDLE with no output.
- DATA:
  - Low nibble first; a byte completes on every second nibble.
  - Each byte updates CRC-32 (reflected, polynomial 0xEDB88320) and increments the byte count.
  - Bytes pack into lane order; a word is issued when OUT_BYTES lanes are filled.
  - With STRIP_FCS=1, bytes pass through a 4-byte delay line, so the FCS never reaches a lane.
- DATA, end of frame: on the first `nib_stb` with dv=0 the frame ends.
  - The partial word is issued with out_last=1 and keep set to the filled lanes.
  - If the frame is shorter than one word plus FCS after stripping, a last word with keep=0 is allowed.
  - The last word is issued within 2 clk of the end `nib_stb`.
  - FSM returns to IDLE.
- out_error = OR of:
  - `ethernet_rx_er` seen in DATA;
  - odd nibble count;
  - CRC register not equal to 0xC704DD7B (only when CHECK_FCS=1);
  - byte count < MIN_LEN.
- Oversize: when byte count reaches MAX_LEN+1, the current word is issued with last=1 and error=1, then the FSM goes to DROP.
- DROP: waits for dv=0, then goes to IDLE; nothing is emitted.
- `start` falling mid-frame: the current frame completes normally and no new frame is accepted.
- Reset mid-frame: outputs clear immediately. If dv is still high after release, that frame is dropped (IDLE sees start but is not at the frame start, so PREAMBLE sees a data nibble and goes to DROP).
- No backpressure: the downstream stage must accept every out_valid.

Decomposition:
- Package `ethernet_pkg`:
  - state encoding;
  - CRC_POLY, CRC_INIT and CRC_RESIDUE=0xC704DD7B;
  - PREAMBLE_NIB=0x5 and SFD_NIB=0xD.
- Sub-module `ethernet_crc32`: byte-wide, combinational next-state plus register, with ports clr, en, data[7:0] and crc[31:0]. It is reusable by the TX path.

Test Plan:
- Good frame, OUT_BYTES=1, MIN_LEN=0.
  - Stimulus: 7x 0x55, 0xD5, then bytes 31..39 ("123456789"), then 26 39 F4 CB, with clk at 4x rx_clk.
  - Required: 13 beats, last on 0xCB, error=0, frame_ok=1.
- Same frame, OUT_BYTES=4, STRIP_FCS=1.
  - Required: words 0x34333231 keep 0xF, 0x38373635 keep 0xF, 0x00000039 keep 0x1 with last=1 and error=0.
- FCS corrupt: last byte 0xCA instead of 0xCB.
  - Required: last=1, error=1, frame_bad pulse, frame_ok stays 0.
- Line errors:
  - rx_er high for one rx_clk in the payload: error=1.
  - Separately, one extra nibble before dv falls: error=1.
- MAX_LEN=8 with the 13-byte frame.
  - Required: last+error on byte 9, nothing more from that frame, busy until dv=0.
  - An immediately following good frame is received with error=0.
- Enable and reset:
  - start=0 during a whole frame: no out_valid.
  - reset asserted at byte 5: outputs 0 asynchronously; with dv still high after release, no output until the next preamble.

Source files
------------

// File: rtl/ethernet_pkg.sv
`default_nettype none
// ============================================================================
// ethernet_pkg : shared MII state encoding, CRC-32 constants and helpers
// Revision     : 1.0
// ============================================================================
package ethernet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PREAMBLE = 2'b01,
    ST_DATA     = 2'b10,
    ST_DROP     = 2'b11
  } rx_state_e;

  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  // Good-frame residue in MSB-first form; the reflected register is bit-reversed before comparing.
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;
  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ethernet_crc32.sv
`default_nettype none
// ============================================================================
// ethernet_crc32 : byte-wide reflected CRC-32 register, shared by RX and TX
// Revision       : 1.0
// ============================================================================
module ethernet_crc32
  import ethernet_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_byte(crc_q, data);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/ethernet_rx_stream.sv
`default_nettype none
// ============================================================================
// ethernet_rx_stream : oversampled MII receiver producing a byte-lane word
//                      stream with FCS check/strip and length policing
// Revision           : 1.0
// ============================================================================
module ethernet_rx_stream
  import ethernet_pkg::*;
#(
  parameter int OUT_BYTES = 1,
  parameter int CHECK_FCS = 1,
  parameter int STRIP_FCS = 0,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   ethernet_rx_clk,
  input  logic                   ethernet_rx_dv,
  input  logic [3:0]             ethernet_rx,
  input  logic                   ethernet_rx_er,
  input  logic                   ethernet_crs,
  output logic                   out_valid,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_last,
  output logic                   out_error,
  output logic                   frame_ok,
  output logic                   frame_bad,
  output logic                   busy
);

  localparam int            CW       = $clog2(OUT_BYTES + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OUT_BYTES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [15:0]   MIN_L    = 16'(MIN_LEN);
  localparam logic [15:0]   OVER_L   = 16'(MAX_LEN + 1);

  logic [6:0]             sync1_q, sync2_q;
  logic                   rxclk_prev_q;
  rx_state_e              state_q, state_d;
  logic                   phase_q, phase_d;
  logic [3:0]             lo_q, lo_d;
  logic [15:0]            bcnt_q, bcnt_d;
  logic                   err_q, err_d;
  logic [31:0]            dly_q, dly_d;
  logic [2:0]             fill_q, fill_d;
  logic [8*OUT_BYTES-1:0] word_q, word_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   flush_q, flush_d, ferr_q, ferr_d;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                   out_error_q, out_error_d;
  logic                   frame_ok_q, frame_ok_d, frame_bad_q, frame_bad_d;
  logic [8*OUT_BYTES-1:0] out_data_q, out_data_d;
  logic [OUT_BYTES-1:0]   out_keep_q, out_keep_d;

  logic        nib_stb, rx_dv, rx_er, crc_clr, byte_stb, emit, fcs_bad;
  logic [3:0]  rx_nib;
  logic [7:0]  rx_byte, emit_byte;
  logic [31:0] crc;

  // Synchroniser bit order: {er, rx[3:0], dv, rx_clk}
  assign nib_stb = sync2_q[0] & ~rxclk_prev_q;
  assign rx_dv   = sync2_q[1];
  assign rx_nib  = sync2_q[5:2];
  assign rx_er   = sync2_q[6];
  assign rx_byte = {rx_nib, lo_q};
  assign fcs_bad = (CHECK_FCS != 0) && (bitrev32(crc) != CRC_RESIDUE);

  ethernet_crc32 u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (byte_stb),
    .data  (rx_byte),
    .crc   (crc)
  );

  always_comb begin
    state_d = state_q;  phase_d = phase_q;  lo_d = lo_q;  bcnt_d = bcnt_q;
    err_d = err_q;  dly_d = dly_q;  fill_d = fill_q;  word_d = word_q;
    cnt_d = cnt_q;  flush_d = 1'b0;  ferr_d = ferr_q;
    crc_clr = 1'b0;  byte_stb = 1'b0;  emit = 1'b0;  emit_byte = rx_byte;
    out_valid_d = 1'b0;  out_data_d = '0;  out_keep_d = '0;  out_last_d = 1'b0;
    out_error_d = 1'b0;  frame_ok_d = 1'b0;  frame_bad_d = 1'b0;

    if (flush_q) begin
      out_valid_d = 1'b1;
      out_data_d  = word_q;
      for (int i = 0; i < OUT_BYTES; i++) begin
        out_keep_d[i] = (CW'(i) < cnt_q);
      end
      out_last_d  = 1'b1;
      out_error_d = ferr_q;
      frame_ok_d  = ~ferr_q;
      frame_bad_d = ferr_q;
      word_d      = '0;
      cnt_d       = '0;
    end

    if (nib_stb) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_dv) state_d = start ? ST_PREAMBLE : ST_DROP;
        end
        ST_PREAMBLE: begin
          if (!rx_dv) begin
            state_d = ST_IDLE;
          end else if (rx_nib == SFD_NIB) begin
            state_d = ST_DATA;
            crc_clr = 1'b1;
            bcnt_d  = '0;
            err_d   = 1'b0;
            phase_d = 1'b0;
            fill_d  = '0;
            word_d  = '0;
            cnt_d   = '0;
          end else if (rx_nib != PREAMBLE_NIB) begin
            state_d = ST_DROP;
          end
        end
        ST_DATA: begin
          if (!rx_dv) begin
            state_d = ST_IDLE;
            flush_d = 1'b1;
            ferr_d  = err_q | phase_q | fcs_bad | (bcnt_q < MIN_L);
          end else begin
            if (rx_er) err_d = 1'b1;
            phase_d = ~phase_q;
            if (!phase_q) begin
              lo_d = rx_nib;
            end else begin
              byte_stb = 1'b1;
              bcnt_d   = bcnt_q + 16'd1;
              if (bcnt_d == OVER_L) begin
                state_d = ST_DROP;
                flush_d = 1'b1;
                ferr_d  = 1'b1;
              end
            end
          end
        end
        ST_DROP: begin
          if (!rx_dv) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The delay line holds the most recent four bytes, which are the FCS at frame end.
    if (byte_stb) begin
      if (STRIP_FCS != 0) begin
        if (fill_q != 3'd4) begin
          fill_d = fill_q + 3'd1;
        end else begin
          emit      = 1'b1;
          emit_byte = dly_q[31:24];
        end
        dly_d = {dly_q[23:0], rx_byte};
      end else begin
        emit = 1'b1;
      end
    end

    // A full word is held until the next byte proves it is not the last one.
    if (emit) begin
      if (cnt_q == CNT_FULL) begin
        out_valid_d = 1'b1;
        out_data_d  = word_q;
        out_keep_d  = '1;
        word_d      = '0;
        word_d[7:0] = emit_byte;
        cnt_d       = CNT_ONE;
      end else begin
        for (int i = 0; i < OUT_BYTES; i++) begin
          if (cnt_q == CW'(i)) word_d[8*i +: 8] = emit_byte;
        end
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;  sync2_q <= '0;  rxclk_prev_q <= 1'b0;
      state_q <= ST_IDLE;  phase_q <= 1'b0;  lo_q <= '0;  bcnt_q <= '0;
      err_q <= 1'b0;  dly_q <= '0;  fill_q <= '0;  word_q <= '0;  cnt_q <= '0;
      flush_q <= 1'b0;  ferr_q <= 1'b0;
      out_valid_q <= 1'b0;  out_data_q <= '0;  out_keep_q <= '0;  out_last_q <= 1'b0;
      out_error_q <= 1'b0;  frame_ok_q <= 1'b0;  frame_bad_q <= 1'b0;
    end else begin
      sync1_q <= {ethernet_rx_er, ethernet_rx, ethernet_rx_dv, ethernet_rx_clk};
      sync2_q <= sync1_q;
      rxclk_prev_q <= sync2_q[0];
      state_q <= state_d;  phase_q <= phase_d;  lo_q <= lo_d;  bcnt_q <= bcnt_d;
      err_q <= err_d;  dly_q <= dly_d;  fill_q <= fill_d;  word_q <= word_d;  cnt_q <= cnt_d;
      flush_q <= flush_d;  ferr_q <= ferr_d;
      out_valid_q <= out_valid_d;  out_data_q <= out_data_d;  out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;  out_error_q <= out_error_d;
      frame_ok_q <= frame_ok_d;  frame_bad_q <= frame_bad_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_error = out_error_q;
  assign frame_ok  = frame_ok_q;
  assign frame_bad = frame_bad_q;
  assign busy      = (state_q != ST_IDLE) | ethernet_crs;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_rx_stream.sv
`default_nettype none
// ============================================================================
// tb_ethernet_rx_stream : scoreboard bench, three parameterisations fed by one
//                         MII stream (1-byte, 4-byte stripped, MAX_LEN=8)
// Revision              : 1.0
// ============================================================================
module tb_ethernet_rx_stream;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        e;
  } exp_t;

  logic clk, reset, start, rx_clk, dv, er, crs;
  logic [3:0] rx;

  logic       a_valid, a_last, a_error, a_ok, a_bad, a_busy;
  logic [7:0] a_data;
  logic [0:0] a_keep;
  logic        b_valid, b_last, b_error, b_ok, b_bad, b_busy;
  logic [31:0] b_data;
  logic [3:0]  b_keep;
  logic       c_valid, c_last, c_error, c_ok, c_bad, c_busy;
  logic [7:0] c_data;
  logic [0:0] c_keep;

  exp_t qa[$], qb[$], qc[$];
  logic [7:0] frm[$];
  int n_checks = 0;
  int n_fail   = 0;

  ethernet_rx_stream #(.OUT_BYTES(1), .CHECK_FCS(1), .STRIP_FCS(0), .MIN_LEN(0), .MAX_LEN(1518)) u_a (
    .clk(clk), .reset(reset), .start(start), .ethernet_rx_clk(rx_clk), .ethernet_rx_dv(dv),
    .ethernet_rx(rx), .ethernet_rx_er(er), .ethernet_crs(crs), .out_valid(a_valid),
    .out_data(a_data), .out_keep(a_keep), .out_last(a_last), .out_error(a_error),
    .frame_ok(a_ok), .frame_bad(a_bad), .busy(a_busy));

  ethernet_rx_stream #(.OUT_BYTES(4), .CHECK_FCS(1), .STRIP_FCS(1), .MIN_LEN(0), .MAX_LEN(1518)) u_b (
    .clk(clk), .reset(reset), .start(start), .ethernet_rx_clk(rx_clk), .ethernet_rx_dv(dv),
    .ethernet_rx(rx), .ethernet_rx_er(er), .ethernet_crs(crs), .out_valid(b_valid),
    .out_data(b_data), .out_keep(b_keep), .out_last(b_last), .out_error(b_error),
    .frame_ok(b_ok), .frame_bad(b_bad), .busy(b_busy));

  ethernet_rx_stream #(.OUT_BYTES(1), .CHECK_FCS(1), .STRIP_FCS(0), .MIN_LEN(0), .MAX_LEN(8)) u_c (
    .clk(clk), .reset(reset), .start(start), .ethernet_rx_clk(rx_clk), .ethernet_rx_dv(dv),
    .ethernet_rx(rx), .ethernet_rx_er(er), .ethernet_crs(crs), .out_valid(c_valid),
    .out_data(c_data), .out_keep(c_keep), .out_last(c_last), .out_error(c_error),
    .frame_ok(c_ok), .frame_bad(c_bad), .busy(c_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_beat(input string tag, input bit have, input exp_t e, input logic [31:0] d,
                          input logic [3:0] k, input logic l, input logic er_o,
                          input logic ok, input logic bad);
    n_checks++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s unexpected beat: data=%h keep=%h last=%b err=%b", tag, d, k, l, er_o);
    end else if (d !== e.d || k !== e.k || l !== e.l || er_o !== e.e ||
                 ok !== (e.l & ~e.e) || bad !== (e.l & e.e)) begin
      n_fail++;
      $display("FAIL %s beat: got data=%h keep=%h last=%b err=%b ok=%b bad=%b, expected data=%h keep=%h last=%b err=%b",
               tag, d, k, l, er_o, ok, bad, e.d, e.k, e.l, e.e);
    end
  endtask

  // Monitors: pop one expectation per presented beat.
  always @(negedge clk) begin
    exp_t e;
    if (a_valid) begin
      e = '0;
      if (qa.size() > 0) e = qa.pop_front();
      cmp_beat("A", qa.size() >= 0 && e != '0, e, {24'h0, a_data}, {3'b0, a_keep}, a_last, a_error, a_ok, a_bad);
    end
    if (b_valid) begin
      e = '0;
      if (qb.size() > 0) e = qb.pop_front();
      cmp_beat("B", e != '0, e, b_data, b_keep, b_last, b_error, b_ok, b_bad);
    end
    if (c_valid) begin
      e = '0;
      if (qc.size() > 0) e = qc.pop_front();
      cmp_beat("C", e != '0, e, {24'h0, c_data}, {3'b0, c_keep}, c_last, c_error, c_ok, c_bad);
    end
  end

  // Byte-lane expectations for the 1-byte configurations; which: 0=A, 2=C.
  task automatic push_bytes(input int which, input int n, input bit err);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = {24'h0, frm[i]};
      e.k = 4'h1;
      e.l = (i == n - 1);
      e.e = (i == n - 1) ? err : 1'b0;
      if (which == 0) qa.push_back(e);
      else qc.push_back(e);
    end
  endtask

  task automatic push_b(input logic [31:0] d, input logic [3:0] k, input logic l, input logic e);
    exp_t x;
    x.d = d; x.k = k; x.l = l; x.e = e;
    qb.push_back(x);
  endtask

  task automatic push_b_good_words(input bit err);
    push_b(32'h34333231, 4'hF, 1'b0, 1'b0);
    push_b(32'h38373635, 4'hF, 1'b0, 1'b0);
    push_b(32'h00000039, 4'h1, 1'b1, err);
  endtask

  task automatic load_good();
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
  endtask

  task automatic nib(input logic [3:0] n, input logic v, input logic e);
    rx = n; dv = v; er = e;
    #20 rx_clk = 1'b1;
    #20 rx_clk = 1'b0;
  endtask

  task automatic preamble();
    for (int i = 0; i < 15; i++) nib(4'h5, 1'b1, 1'b0);
    nib(4'hD, 1'b1, 1'b0);
  endtask

  task automatic send_frame(input int er_idx, input bit extra, input bit chk_busy);
    preamble();
    for (int i = 0; i < frm.size(); i++) begin
      nib(frm[i][3:0], 1'b1, i == er_idx);
      nib(frm[i][7:4], 1'b1, 1'b0);
      if (chk_busy && i == 11) chk("busy_c_in_drop", {31'h0, c_busy}, 32'h1);
    end
    if (extra) nib(4'h0, 1'b1, 1'b0);
    nib(4'h0, 1'b0, 1'b0);
    nib(4'h0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    if (chk_busy) chk("busy_c_after_dv_low", {31'h0, c_busy}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1'b0; start = 1'b0; rx_clk = 1'b0; dv = 1'b0; er = 1'b0; crs = 1'b0; rx = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_a_outs", {26'h0, a_valid, a_last, a_error, a_ok, a_bad, a_busy}, 32'h0);
    chk("reset_b_data_keep", b_data | {28'h0, b_keep}, 32'h0);
    chk("reset_c_valid_busy", {30'h0, c_valid, c_busy}, 32'h0);
    reset = 1'b1;
    start = 1'b1;
    repeat (4) @(negedge clk);

    // Good frame "123456789" + FCS.
    load_good();
    push_bytes(0, 13, 1'b0);
    push_b_good_words(1'b0);
    push_bytes(2, 9, 1'b1);
    send_frame(-1, 1'b0, 1'b1);

    // Shortest good frame: empty payload, FCS 00000000; 4 bytes fit MAX_LEN=8.
    frm = {8'h00, 8'h00, 8'h00, 8'h00};
    push_bytes(0, 4, 1'b0);
    push_b(32'h0, 4'h0, 1'b1, 1'b0);
    push_bytes(2, 4, 1'b0);
    send_frame(-1, 1'b0, 1'b0);

    // Corrupt FCS.
    load_good();
    frm[12] = 8'hCA;
    push_bytes(0, 13, 1'b1);
    push_b_good_words(1'b1);
    push_bytes(2, 9, 1'b1);
    send_frame(-1, 1'b0, 1'b0);

    // rx_er for one rx_clk inside the payload.
    load_good();
    push_bytes(0, 13, 1'b1);
    push_b_good_words(1'b1);
    push_bytes(2, 9, 1'b1);
    send_frame(2, 1'b0, 1'b0);

    // One extra nibble: odd nibble count.
    load_good();
    push_bytes(0, 13, 1'b1);
    push_b_good_words(1'b1);
    push_bytes(2, 9, 1'b1);
    send_frame(-1, 1'b1, 1'b0);

    // Receive disabled for the whole frame.
    start = 1'b0;
    load_good();
    send_frame(-1, 1'b0, 1'b0);
    start = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted after byte 5; bytes 1..4 already emitted by the 1-byte configs.
    load_good();
    for (int i = 0; i < 4; i++) begin
      e.d = {24'h0, frm[i]}; e.k = 4'h1; e.l = 1'b0; e.e = 1'b0;
      qa.push_back(e);
      qc.push_back(e);
    end
    preamble();
    for (int i = 0; i < 5; i++) begin
      nib(frm[i][3:0], 1'b1, 1'b0);
      nib(frm[i][7:4], 1'b1, 1'b0);
    end
    repeat (6) @(negedge clk);
    chk("busy_a_before_reset", {31'h0, a_busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_a_outs", {26'h0, a_valid, a_last, a_error, a_ok, a_bad, a_busy}, 32'h0);
    chk("async_reset_bc_busy", {30'h0, b_busy, c_busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 5; i < 13; i++) begin
      nib(frm[i][3:0], 1'b1, 1'b0);
      nib(frm[i][7:4], 1'b1, 1'b0);
    end
    nib(4'h0, 1'b0, 1'b0);
    nib(4'h0, 1'b0, 1'b0);

    // Recovery frame after reset.
    frm = {8'h00, 8'h00, 8'h00, 8'h00};
    push_bytes(0, 4, 1'b0);
    push_b(32'h0, 4'h0, 1'b1, 1'b0);
    push_bytes(2, 4, 1'b0);
    send_frame(-1, 1'b0, 1'b0);

    repeat (20) @(negedge clk);
    chk("qa_drained", qa.size(), 32'h0);
    chk("qb_drained", qb.size(), 32'h0);
    chk("qc_drained", qc.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
